// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the 16-bit MIPS core.
// Owns the PC addressing the combinational instruction ROM and the IF/ID
// register. Handles sequential fetch, stall, jump/branch redirects with
// bubble insertion, halt/resume and a saturating fetch counter.
// Optional feature macro: FETCH_BOUND_EN (ROM bound check, S_FAULT state,
// fetch_fault port).
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned ROM_WORDS = 16,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] pc,
  input  logic [15:0] instr_in,
  input  logic        stall,
  input  logic        jump,
  input  logic [11:0] jump_target,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        halt,
  input  logic        resume,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc2,
  output logic        if_id_valid,
  output logic        halted,
`ifdef FETCH_BOUND_EN
  output logic        fetch_fault,
`endif
  output logic [15:0] fetch_count
);

`ifdef FETCH_BOUND_EN
  typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;
`else
  typedef enum logic {S_RUN, S_HALT} state_t;
`endif

  // Elaboration-time sanity check on the configuration.
  if (ROM_WORDS == 0 || RESET_PC[0] != 1'b0) begin : g_param_check
    $error("fetch_ctrl: ROM_WORDS must be nonzero and RESET_PC even");
  end

  state_t      state_q, state_d;
  // PC is stored as a word address; bit 0 is always zero on the port.
  logic [14:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc2_q, pc2_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;

  logic [14:0] seq_w;
  logic [14:0] jmp_w;
  logic [14:0] br_w;
  logic [14:0] tgt_w;
  logic        load_pc;
  logic        bubble;
  logic        fetch;

  logic        unused_bits;
  assign unused_bits = branch_target[0];

  assign seq_w = pc_q + 15'd1;
  assign jmp_w = {pc_q[14:12], jump_target};
  assign br_w  = branch_target[15:1];

  // State and IF/ID register update; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC[15:1];
      instr_q <= NOP_INSTR;
      pc2_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc2_q   <= pc2_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: pick the PC source by priority, then apply the
  // common bubble/fetch effects on IF/ID once the source is settled.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc2_d   = pc2_q;
    valid_d = valid_q;
    count_d = count_q;
    tgt_w   = seq_w;
    load_pc = 1'b0;
    bubble  = 1'b0;
    fetch   = 1'b0;

    case (state_q)
      S_RUN: begin
        if (branch_taken) begin
          tgt_w   = br_w;
          load_pc = 1'b1;
          bubble  = 1'b1;
        end else if (jump) begin
          tgt_w   = jmp_w;
          load_pc = 1'b1;
          bubble  = 1'b1;
        end else if (halt) begin
          state_d = S_HALT;
          bubble  = 1'b1;
        end else if (!stall) begin
          tgt_w   = seq_w;
          load_pc = 1'b1;
          fetch   = 1'b1;
        end
      end
      S_HALT: begin
        valid_d = 1'b0;
        if (resume) begin
          state_d = S_RUN;
        end
      end
`ifdef FETCH_BOUND_EN
      S_FAULT: begin
        valid_d = 1'b0;
      end
`endif
      default: begin
        state_d = S_RUN;
      end
    endcase

    if (load_pc) begin
`ifdef FETCH_BOUND_EN
      // An out-of-range destination aborts the load: pc keeps its last
      // legal value and the would-be fetch becomes a bubble.
      if (32'(tgt_w) >= ROM_WORDS) begin
        state_d = S_FAULT;
        bubble  = 1'b1;
        fetch   = 1'b0;
      end else begin
        pc_d = tgt_w;
      end
`else
      pc_d = tgt_w;
`endif
    end

    if (bubble) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end

    if (fetch) begin
      instr_d = instr_in;
      pc2_d   = {seq_w, 1'b0};
      valid_d = 1'b1;
      if (count_q != '1) begin
        count_d = count_q + 16'd1;
      end
    end
  end

  assign pc          = {pc_q, 1'b0};
  assign if_id_instr = instr_q;
  assign if_id_pc2   = pc2_q;
  assign if_id_valid = valid_q;
  assign fetch_count = count_q;
  assign halted      = (state_q == S_HALT);
`ifdef FETCH_BOUND_EN
  assign fetch_fault = (state_q == S_FAULT);
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven, scoreboard-checked bench for fetch_ctrl.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] instr_in;
  logic        stall;
  logic        jump;
  logic [11:0] jump_target;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt;
  logic        resume;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc2;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_count;
`ifdef FETCH_BOUND_EN
  logic        fetch_fault;
`endif

  logic [15:0] rom [16];
  int unsigned n_cmp;
  int unsigned n_bad;

  fetch_ctrl #(
    .RESET_PC (16'h0000),
    .ROM_WORDS(16),
    .NOP_INSTR(16'h0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .instr_in     (instr_in),
    .stall        (stall),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .halt         (halt),
    .resume       (resume),
    .if_id_instr  (if_id_instr),
    .if_id_pc2    (if_id_pc2),
    .if_id_valid  (if_id_valid),
    .halted       (halted),
`ifdef FETCH_BOUND_EN
    .fetch_fault  (fetch_fault),
`endif
    .fetch_count  (fetch_count)
  );

  // Combinational ROM model indexed by pc[4:1].
  assign instr_in = rom[pc[4:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, stl, jmp;
    logic [11:0] jt;
    logic        br;
    logic [15:0] bt;
    logic        hlt, res;
    logic [15:0] e_pc, e_instr, e_pc2;
    logic        e_v, e_h;
    logic [15:0] e_cnt;
    logic        e_f;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic add(input string nm, input logic rst, input logic stl,
                     input logic jmp, input logic [11:0] jt, input logic br,
                     input logic [15:0] bt, input logic hlt, input logic res,
                     input logic [15:0] e_pc, input logic [15:0] e_instr,
                     input logic [15:0] e_pc2, input logic e_v, input logic e_h,
                     input logic [15:0] e_cnt, input logic e_f);
    vec_t v;
    v.name = nm; v.rst = rst; v.stl = stl; v.jmp = jmp; v.jt = jt;
    v.br = br; v.bt = bt; v.hlt = hlt; v.res = res;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc2 = e_pc2;
    v.e_v = e_v; v.e_h = e_h; v.e_cnt = e_cnt; v.e_f = e_f;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset         = v.rst;
    stall         = v.stl;
    jump          = v.jmp;
    jump_target   = v.jt;
    branch_taken  = v.br;
    branch_target = v.bt;
    halt          = v.hlt;
    resume        = v.res;
  endtask

  initial begin
    vec_t v;
    vec_t e;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 16; i++) rom[i] = 16'h1001 + 16'(i);
    reset = 1'b1; stall = 1'b0; jump = 1'b0; jump_target = '0;
    branch_taken = 1'b0; branch_target = '0; halt = 1'b0; resume = 1'b0;

    //  name         rst stl jmp jt      br bt        hlt res  pc       instr    pc2      v  h  cnt    f
    add("rst0",      1, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 0);
    add("seq1",      0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0002, 16'h1001, 16'h0002, 1, 0, 16'd1, 0);
    add("seq2",      0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0004, 16'h1002, 16'h0004, 1, 0, 16'd2, 0);
    add("seq3",      0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0006, 16'h1003, 16'h0006, 1, 0, 16'd3, 0);
    add("seq4",      0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0008, 16'h1004, 16'h0008, 1, 0, 16'd4, 0);
    add("seq5",      0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h000A, 16'h1005, 16'h000A, 1, 0, 16'd5, 0);
    add("rst1",      1, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 0);
    add("pre_st_a",  0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0002, 16'h1001, 16'h0002, 1, 0, 16'd1, 0);
    add("pre_st_b",  0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0004, 16'h1002, 16'h0004, 1, 0, 16'd2, 0);
    add("pre_st_c",  0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0006, 16'h1003, 16'h0006, 1, 0, 16'd3, 0);
    add("stall1",    0, 1, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0006, 16'h1003, 16'h0006, 1, 0, 16'd3, 0);
    add("stall2",    0, 1, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0006, 16'h1003, 16'h0006, 1, 0, 16'd3, 0);
    add("stall3",    0, 1, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0006, 16'h1003, 16'h0006, 1, 0, 16'd3, 0);
    add("unstall",   0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0008, 16'h1004, 16'h0008, 1, 0, 16'd4, 0);
    add("rst2",      1, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 0);
    add("pre_j_a",   0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0002, 16'h1001, 16'h0002, 1, 0, 16'd1, 0);
    add("pre_j_b",   0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0004, 16'h1002, 16'h0004, 1, 0, 16'd2, 0);
    add("jump",      0, 0, 1, 12'h005, 0, 16'h0000, 0, 0, 16'h000A, 16'h0000, 16'h0004, 0, 0, 16'd2, 0);
    add("post_jump", 0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h000C, 16'h1006, 16'h000C, 1, 0, 16'd3, 0);
    add("br_wins",   0, 1, 1, 12'h7FF, 1, 16'h0003, 1, 0, 16'h0002, 16'h0000, 16'h000C, 0, 0, 16'd3, 0);
    add("post_br",   0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0004, 16'h1002, 16'h0004, 1, 0, 16'd4, 0);
    add("pre_h_a",   0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0006, 16'h1003, 16'h0006, 1, 0, 16'd5, 0);
    add("pre_h_b",   0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0008, 16'h1004, 16'h0008, 1, 0, 16'd6, 0);
    add("halt",      0, 0, 0, 12'h000, 0, 16'h0000, 1, 0, 16'h0008, 16'h0000, 16'h0008, 0, 1, 16'd6, 0);
    add("halt_jmp",  0, 0, 1, 12'h001, 0, 16'h0000, 0, 0, 16'h0008, 16'h0000, 16'h0008, 0, 1, 16'd6, 0);
    add("halt_br",   0, 0, 0, 12'h000, 1, 16'h0010, 0, 0, 16'h0008, 16'h0000, 16'h0008, 0, 1, 16'd6, 0);
    add("halt_stl",  0, 1, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0008, 16'h0000, 16'h0008, 0, 1, 16'd6, 0);
    add("resume",    0, 0, 0, 12'h000, 0, 16'h0000, 0, 1, 16'h0008, 16'h0000, 16'h0008, 0, 0, 16'd6, 0);
    add("post_res",  0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h000A, 16'h1005, 16'h000A, 1, 0, 16'd7, 0);
    add("res_run",   0, 0, 0, 12'h000, 0, 16'h0000, 0, 1, 16'h000C, 16'h1006, 16'h000C, 1, 0, 16'd8, 0);
    add("halt2",     0, 0, 0, 12'h000, 0, 16'h0000, 1, 0, 16'h000C, 16'h0000, 16'h000C, 0, 1, 16'd8, 0);
    add("rst_halt",  1, 0, 0, 12'h000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 0);
    add("jump_1e",   0, 0, 1, 12'h00F, 0, 16'h0000, 0, 0, 16'h001E, 16'h0000, 16'h0000, 0, 0, 16'd0, 0);
`ifdef FETCH_BOUND_EN
    add("bound",     0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h001E, 16'h0000, 16'h0000, 0, 0, 16'd0, 1);
    add("bound_res", 0, 0, 0, 12'h000, 0, 16'h0000, 0, 1, 16'h001E, 16'h0000, 16'h0000, 0, 0, 16'd0, 1);
    add("rst_fault", 1, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 0);
    add("br_far",    0, 0, 0, 12'h000, 1, 16'hFFFF, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 1);
    add("br_far_2",  0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 1);
`else
    add("alias",     0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0020, 16'h1010, 16'h0020, 1, 0, 16'd1, 0);
    add("alias_2",   0, 0, 0, 12'h000, 0, 16'h0000, 0, 1, 16'h0022, 16'h1001, 16'h0022, 1, 0, 16'd2, 0);
    add("rst_alias", 1, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 0);
    add("br_far",    0, 0, 0, 12'h000, 1, 16'hFFFF, 0, 0, 16'hFFFE, 16'h0000, 16'h0000, 0, 0, 16'd0, 0);
    add("wrap",      0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0000, 16'h1010, 16'h0000, 1, 0, 16'd1, 0);
`endif
    add("rst_w",     1, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 0);
    add("pre_rs",    0, 0, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0002, 16'h1001, 16'h0002, 1, 0, 16'd1, 0);
    add("stall_rs",  0, 1, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0002, 16'h1001, 16'h0002, 1, 0, 16'd1, 0);
    add("rst_stall", 1, 1, 0, 12'h000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      v = vecs[i];
      drive(v);
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({e.name, ".pc"},    pc,                 e.e_pc);
      chk({e.name, ".instr"}, if_id_instr,        e.e_instr);
      chk({e.name, ".pc2"},   if_id_pc2,          e.e_pc2);
      chk({e.name, ".valid"}, 16'(if_id_valid),   16'(e.e_v));
      chk({e.name, ".halted"},16'(halted),        16'(e.e_h));
      chk({e.name, ".count"}, fetch_count,        e.e_cnt);
`ifdef FETCH_BOUND_EN
      chk({e.name, ".fault"}, 16'(fetch_fault),   16'(e.e_f));
`endif
    end

    // Counter saturation: 7 fetches then a jump back to 0, kept inside the ROM.
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; jump = 1'b0; jump_target = '0;
    branch_taken = 1'b0; halt = 1'b0; resume = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 75000; i++) begin
      @(negedge clk);
      reset = 1'b0;
      jump  = ((i % 8) == 7);
      @(posedge clk);
      #1;
      if (i == 7) begin
        chk("sat.count8", fetch_count, 16'd7);
        chk("sat.pc8",    pc,          16'h0000);
      end
    end
    chk("sat.count_max", fetch_count, 16'hFFFF);
    @(negedge clk);
    jump = 1'b0;
    @(posedge clk);
    #1;
    chk("sat.hold", fetch_count, 16'hFFFF);
    chk("sat.valid", 16'(if_id_valid), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the 16-bit MIPS core. It owns the program counter that addresses the combinational 16-word instruction ROM and captures the returned instruction into the IF/ID pipeline register. It handles sequential fetch, stall, jump and branch redirects with bubble insertion, halt/resume, and a fetch counter.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset; must be even.
ROM_WORDS, 16, instruction ROM depth in 16-bit words; used only by the optional bound check.
NOP_INSTR, 16'h0000, encoding placed in if_id_instr when a bubble is inserted.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
pc  output  16  fetch address to the instruction ROM; the ROM indexes it with pc[4:1].
instr_in  input  16  instruction returned combinationally by the ROM for the current pc.
stall  input  1  hazard unit: hold pc and IF/ID.
jump  input  1  ID stage resolved a jump this cycle.
jump_target  input  12  word-offset jump field.
branch_taken  input  1  EX stage resolved a taken branch this cycle.
branch_target  input  16  absolute branch destination; bit 0 ignored.
halt  input  1  ID stage decoded a halt instruction.
resume  input  1  single-cycle pulse that leaves the halted state.
if_id_instr  output  16  registered instruction to decode.
if_id_pc2  output  16  registered PC+2 of if_id_instr.
if_id_valid  output  1  if_id_instr is a real instruction, not a bubble.
halted  output  1  high while in S_HALT.
fetch_count  output  16  saturating count of valid fetches.
fetch_fault  output  1  out-of-range fetch; present only with the optional feature.

Behaviour:
- Reset (synchronous, overrides everything):
  - pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc2=0, if_id_valid=0.
  - halted=0, fetch_count=0, fetch_fault=0, state=S_RUN.
- States: S_RUN, S_HALT, S_FAULT. S_FAULT exists only with FETCH_BOUND_EN.
- Arithmetic:
  - PC increment is pc+2, modulo 2^16; wrap from 16'hFFFE to 16'h0000 is silent.
  - Jump target = {pc[15:13], jump_target, 1'b0}, using the current fetch pc.
  - Branch target = {branch_target[15:1], 1'b0}.
  - pc[0] is always 0.
- Priority in S_RUN, evaluated each cycle, highest first:
  1. branch_taken: pc<=branch target; IF/ID<=bubble (if_id_valid=0, if_id_instr=NOP_INSTR). Stall, jump and halt are ignored because they are younger and flushed.
  2. jump: pc<=jump target; IF/ID<=bubble. Stall and halt are ignored.
  3. halt: state<=S_HALT; pc holds; IF/ID<=bubble. The pc already points past the halt instruction.
  4. stall: pc, if_id_instr, if_id_pc2 and if_id_valid all hold.
  5. Otherwise: pc<=pc+2; if_id_instr<=instr_in; if_id_pc2<=pc+2; if_id_valid<=1; fetch_count increments, saturating at 16'hFFFF.
- Latency: one cycle from pc presented to instruction visible in IF/ID. Redirect penalty is one bubble for jump; for branch it is the bubble plus the flush of the ID-stage instruction, which the hazard unit handles.
- S_HALT:
  - halted=1, pc frozen, if_id_valid=0, fetch_count frozen; stall, jump and branch inputs are ignored.
  - resume=1 -> S_RUN next cycle; fetch restarts at the held pc with no extra bubble.
  - A resume asserted outside S_HALT has no effect.
- fetch_count counts only cycles that load if_id_valid=1.
- A reset asserted mid-stall or mid-halt takes effect on that edge with no residual state.

Optional Feature:
FETCH_BOUND_EN
- Defined:
  - Any cycle in S_RUN where the next pc would load a value with pc[15:1] >= ROM_WORDS moves to S_FAULT instead: fetch_fault<=1, pc holds its last legal value, IF/ID<=bubble.
  - The check covers sequential increment, jump and branch.
  - S_FAULT is left only by reset; resume is ignored.
- Undefined: no bound check and no S_FAULT; fetch_fault is not a port. Addresses alias through pc[4:1].

Test Plan:
1. Reset, then run 5 cycles with ROM words 0..4 = 16'h1001..16'h1005 -> pc sequence 0,2,4,6,8,10; if_id_instr = 1001..1005; if_id_pc2 = 2..10; fetch_count=5.
2. stall high for 3 cycles at pc=6 -> pc stays 6 and IF/ID holds 16'h1003 with valid=1; fetch_count unchanged; sequence resumes at 6 once stall drops.
3. jump with jump_target=12'h005 at pc=4 -> next pc=16'h000A; one cycle with if_id_valid=0 and if_id_instr=0000; next if_id_instr=rom[5].
4. branch_taken=1, branch_target=16'h0003, with jump=1 and stall=1 in the same cycle -> pc=16'h0002 (branch wins, bit 0 cleared); bubble inserted.
5. halt at pc=8 -> halted=1, pc holds 8, if_id_valid=0 for 4 cycles despite a jump pulse; resume pulse -> next cycle fetches rom[4] with if_id_pc2=10.
6. With FETCH_BOUND_EN and ROM_WORDS=16, sequential run from pc=16'h001E -> fetch_fault=1, pc holds 1E, if_id_valid=0; only reset clears. Without the macro -> pc=16'h0020 and if_id_instr=rom[0].
